// File: rtl/sifh_hist_reader_pkg.sv
// Shared SiFH histogram-readout definitions: RAM geometry, count width and
// the readout state encoding.
package sifh_hist_reader_pkg;

  localparam int NB        = 4;
  localparam int NPIX_W    = 2;
  localparam int RAM_ADDR  = NB + NPIX_W;
  localparam int PEAK_MAX  = 8;
  localparam int BIN_NUM   = 2 ** NB;
  localparam int PIXEL_NUM = 2 ** NPIX_W;

  // Terminal counter values, compared explicitly so counters never wrap.
  localparam logic [NB-1:0]     BIN_LAST = '1;
  localparam logic [NPIX_W-1:0] PIX_LAST = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sifh_hist_reader_peak_tracker.sv
// Running max/argmax register. The first sample of a histogram loads
// unconditionally; later samples replace the stored peak only when strictly
// larger, so ties keep the lowest bin index.
module sifh_peak_tracker
  import sifh_hist_reader_pkg::*;
(
  input  logic                clk,
  input  logic                res,
  input  logic                load_first,
  input  logic                sample_en,
  input  logic [NB-1:0]       bin_in,
  input  logic [PEAK_MAX-1:0] count_in,
  output logic [NB-1:0]       max_bin,
  output logic [PEAK_MAX-1:0] max_cnt
);

  logic [NB-1:0]       r_max_bin;
  logic [PEAK_MAX-1:0] r_max_cnt;
  logic                w_take;

  assign w_take = sample_en && (load_first || (count_in > r_max_cnt));

  // Peak register: load on first bin or on a strictly larger count.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_max_bin <= '0;
      r_max_cnt <= '0;
    end else if (w_take) begin
      r_max_bin <= bin_in;
      r_max_cnt <= count_in;
    end
  end

  assign max_bin = r_max_bin;
  assign max_cnt = r_max_cnt;

endmodule

// File: rtl/sifh_hist_reader.sv
// SiFH histogram readout: scans every pixel's bins over RAM port B, tracks
// the peak per pixel, streams {pixel, bin, count} over valid/ready and
// optionally zeroes each bin over port A one cycle after it is read.
module sifh_hist_reader
  import sifh_hist_reader_pkg::*;
#(
  parameter int CLEAR_ON_READ = 1
)
(
  input  logic                clk,
  input  logic                res,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [RAM_ADDR-1:0] raddr,
  output logic                readFlag,
  input  logic [PEAK_MAX-1:0] counts,
  output logic [RAM_ADDR-1:0] waddr,
  output logic                writeFlag,
  output logic                wEnable,
  output logic [PEAK_MAX-1:0] newCounts,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NPIX_W-1:0]   out_pixel,
  output logic [NB-1:0]       out_bin,
  output logic [PEAK_MAX-1:0] out_count
);

  localparam bit CLR = (CLEAR_ON_READ != 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NPIX_W-1:0]   r_pix;
  logic [NB-1:0]       r_bin;
  logic                w_busy;
  logic                w_done;
  logic                w_read;
  logic                w_valid;
  logic                w_last_bin;
  logic                w_last_pix;

  logic                r_rd_vld_p1;
  logic [NB-1:0]       r_rd_bin_p1;
  logic [RAM_ADDR-1:0] r_rd_addr_p1;
  logic [NB-1:0]       w_max_bin;
  logic [PEAK_MAX-1:0] w_max_cnt;

  assign w_last_bin = (r_bin == BIN_LAST);
  assign w_last_pix = (r_pix == PIX_LAST);

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs; out_valid depends on state only.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_read      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = SCAN;
      end
      SCAN: begin
        w_busy = 1'b1;
        w_read = 1'b1;
        if (w_last_bin) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = EMIT;
      end
      EMIT: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        if (out_ready) w_state_nxt = w_last_pix ? DONE : SCAN;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pixel/bin counters; terminal values are held, never wrapped.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_pix <= '0;
      r_bin <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pix <= '0;
            r_bin <= '0;
          end
        end
        SCAN: begin
          if (!w_last_bin) r_bin <= r_bin + 1'b1;
        end
        EMIT: begin
          if (out_ready && !w_last_pix) begin
            r_pix <= r_pix + 1'b1;
            r_bin <= '0;
          end
        end
        DONE: begin
          r_pix <= '0;
          r_bin <= '0;
        end
        default: ;
      endcase
    end
  end

  // Stage p0 -> p1: delay read-issue info to line up with the RAM data.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_bin_p1  <= '0;
      r_rd_addr_p1 <= '0;
    end else begin
      r_rd_vld_p1  <= w_read;
      r_rd_bin_p1  <= r_bin;
      r_rd_addr_p1 <= {r_pix, r_bin};
    end
  end

  sifh_peak_tracker u_peak (
    .clk        (clk),
    .res        (res),
    .load_first (r_rd_bin_p1 == '0),
    .sample_en  (r_rd_vld_p1),
    .bin_in     (r_rd_bin_p1),
    .count_in   (counts),
    .max_bin    (w_max_bin),
    .max_cnt    (w_max_cnt)
  );

  assign busy      = w_busy;
  assign done      = w_done;
  assign readFlag  = w_read;
  assign raddr     = {r_pix, r_bin};
  assign writeFlag = CLR && r_rd_vld_p1;
  assign wEnable   = CLR && r_rd_vld_p1;
  assign waddr     = CLR ? r_rd_addr_p1 : '0;
  assign newCounts = '0;
  assign out_valid = w_valid;
  assign out_pixel = r_pix;
  assign out_bin   = w_max_bin;
  assign out_count = w_max_cnt;

endmodule

// File: tb/tb_sifh_hist_reader.sv
// Bench for sifh_hist_reader: behavioural dual-port RAM, table of pixel
// histograms with hand-derived peaks, scoreboard of expected results.
module tb_sifh_hist_reader;
  import sifh_hist_reader_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, readFlag, writeFlag, wEnable, out_valid;
  logic [RAM_ADDR-1:0] raddr, waddr;
  logic [PEAK_MAX-1:0] counts, newCounts, out_count;
  logic [NPIX_W-1:0]   out_pixel;
  logic [NB-1:0]       out_bin;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sifh_hist_reader #(.CLEAR_ON_READ(1)) dut (
    .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
    .raddr(raddr), .readFlag(readFlag), .counts(counts),
    .waddr(waddr), .writeFlag(writeFlag), .wEnable(wEnable),
    .newCounts(newCounts), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_bin(out_bin), .out_count(out_count)
  );

  // RAM model: port B 1-cycle read, port A write, plus a bench load port.
  logic [7:0] mem [64];
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  always @(posedge clk) begin
    if (readFlag) counts <= mem[raddr];
    if (writeFlag && wEnable) mem[waddr] <= newCounts;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Pixel histogram records: base fill, up to 4 (bin,value) overrides, peak.
  typedef struct {
    logic [7:0] base;
    int         n;
    logic [3:0] ob [4];
    logic [7:0] ov [4];
    logic [3:0] eb;
    logic [7:0] ec;
  } rec_t;
  rec_t recs [8];

  task automatic set_rec(input int i, input logic [7:0] base, input int n,
                         input logic [15:0] o0, input logic [15:0] o1,
                         input logic [15:0] o2, input logic [15:0] o3,
                         input logic [3:0] eb, input logic [7:0] ec);
    recs[i].base = base; recs[i].n = n;
    recs[i].ob[0] = o0[11:8]; recs[i].ov[0] = o0[7:0];
    recs[i].ob[1] = o1[11:8]; recs[i].ov[1] = o1[7:0];
    recs[i].ob[2] = o2[11:8]; recs[i].ov[2] = o2[7:0];
    recs[i].ob[3] = o3[11:8]; recs[i].ov[3] = o3[7:0];
    recs[i].eb = eb; recs[i].ec = ec;
  endtask

  task automatic load_scan(input int first);
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] v;
        v = recs[first+p].base;
        for (int k = 0; k < recs[first+p].n; k++)
          if (recs[first+p].ob[k] == 4'(b)) v = recs[first+p].ov[k];
        ld_en = 1'b1; ld_addr = 6'(p*16 + b); ld_data = v;
        @(posedge clk); #1;
      end
    end
    ld_en = 1'b0;
  endtask

  // Scoreboard of expected {pixel, bin, count} results.
  typedef struct packed {
    logic [NPIX_W-1:0]   pix;
    logic [NB-1:0]       bin;
    logic [PEAK_MAX-1:0] cnt;
  } res_t;
  res_t sb [$];

  task automatic push_scan(input int first);
    for (int p = 0; p < 4; p++)
      sb.push_back('{pix: 2'(p), bin: recs[first+p].eb, cnt: recs[first+p].ec});
  endtask

  // Output monitor: handshakes, clear writes trailing reads, done pulses.
  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic       prev_rf = 1'b0;
  logic [5:0] prev_ra = '0;
  always @(negedge clk) begin
    if (!res) begin
      prev_rf = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: got pix=%0d bin=%0d cnt=%0d expected none",
                   out_pixel, out_bin, out_count);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("result", 64'({out_pixel, out_bin, out_count}), 64'(e));
        end
      end
      if (writeFlag) begin
        wr_cnt++;
        chk("clear_write", 64'({wEnable, prev_rf, newCounts, waddr}),
            64'({1'b1, 1'b1, 8'd0, prev_ra}));
      end
      if (done) done_cnt++;
      prev_rf = readFlag;
      prev_ra = raddr;
    end
  end

  task automatic scan_run(output int cyc, output int busy_hi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busy_hi = busy ? 1 : 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_hi++;
    end
    chk("scan_done_seen", 64'(done), 64'(1));
  endtask

  initial begin
    int cyc, bh, nz;
    logic [13:0] held;

    set_rec(0, 8'd0, 4, {8'd0, 8'd3}, {8'd1, 8'd9}, {8'd2, 8'd2}, {8'd3, 8'd9}, 4'd1, 8'd9);
    set_rec(1, 8'd5, 1, {8'd7, 8'd6}, 16'd0, 16'd0, 16'd0, 4'd7, 8'd6);
    set_rec(2, 8'd0, 0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0, 8'd0);
    set_rec(3, 8'd0, 1, {8'd15, 8'd255}, 16'd0, 16'd0, 16'd0, 4'd15, 8'd255);
    set_rec(4, 8'd7, 0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0, 8'd7);
    set_rec(5, 8'd0, 2, {8'd0, 8'd200}, {8'd8, 8'd201}, 16'd0, 16'd0, 4'd8, 8'd201);
    set_rec(6, 8'd1, 2, {8'd14, 8'd255}, {8'd15, 8'd255}, 16'd0, 16'd0, 4'd14, 8'd255);
    set_rec(7, 8'd0, 3, {8'd5, 8'd128}, {8'd6, 8'd127}, {8'd9, 8'd128}, 16'd0, 4'd5, 8'd128);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, done, readFlag, writeFlag, wEnable, out_valid}), 64'(0));
    chk("reset_addr", 64'({raddr, waddr, newCounts}), 64'(0));
    chk("reset_fields", 64'({out_pixel, out_bin, out_count}), 64'(0));
    res = 1'b1;
    @(posedge clk); #1;

    // Scan 1: free-running output, full clear
    load_scan(0);
    push_scan(0);
    out_ready = 1'b1; wr_cnt = 0; done_cnt = 0;
    scan_run(cyc, bh);
    chk("start_to_done_cycles", 64'(cyc), 64'(PIXEL_NUM*(BIN_NUM+2)+1));
    chk("busy_cycles", 64'(bh), 64'(PIXEL_NUM*(BIN_NUM+2)));
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("clear_writes", 64'(wr_cnt), 64'(64));
    nz = 0;
    for (int a = 0; a < 64; a++) if (mem[a] != 8'd0) nz++;
    chk("ram_cleared", 64'(nz), 64'(0));
    chk("sb_drained_1", 64'(sb.size()), 64'(0));

    // Scan 2: stall first EMIT, stray starts mid-scan and in DONE
    load_scan(4);
    push_scan(4);
    out_ready = 1'b0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("emit_reached", 64'(out_valid), 64'(1));
    held = {out_pixel, out_bin, out_count};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_hold", 64'({out_valid, readFlag, writeFlag, out_pixel, out_bin, out_count}),
          64'({1'b1, 1'b0, 1'b0, held}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("resume_scan", 64'({readFlag, raddr}), 64'({1'b1, 6'd16}));
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("scan2_done_seen", 64'(done), 64'(1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", 64'({busy, readFlag, done}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("scan2_done_pulses", 64'(done_cnt), 64'(1));
    chk("scan2_clear_writes", 64'(wr_cnt), 64'(64));
    chk("sb_drained_2", 64'(sb.size()), 64'(0));

    // Reset during pixel 1 scan
    load_scan(0);
    push_scan(0);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(readFlag && raddr == 6'h13) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach_pix1", 64'({readFlag, raddr}), 64'({1'b1, 6'h13}));
    res = 1'b0;
    #1;
    chk("abort_ctrl", 64'({busy, done, readFlag, writeFlag, wEnable, out_valid}), 64'(0));
    chk("abort_addr", 64'({raddr, waddr, newCounts}), 64'(0));
    chk("abort_fields", 64'({out_pixel, out_bin, out_count}), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_ram", 64'({mem[16], mem[18], mem[63]}), 64'({8'd0, 8'd5, 8'd255}));
    res = 1'b1;
    @(posedge clk); #1;
    load_scan(0);
    push_scan(0);
    scan_run(cyc, bh);
    chk("restart_cycles", 64'(cyc), 64'(PIXEL_NUM*(BIN_NUM+2)+1));
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained_3", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
